// File: rtl/pu_axi_read_gate.sv
// AXI4 read gate: holds one AR at a time, asks PolicyCheck for a verdict, then either
// forwards the burst downstream or answers the master locally with DECERR beats.
module pu_axi_read_gate #(
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // upstream (untrusted master)
  input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]   S_AXI_RID,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  // downstream (interconnect)
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  // PolicyCheck interface
  output logic [ID_WIDTH-1:0]   PC_ID,
  output logic [ADDR_WIDTH-1:0] PC_ADDR,
  output logic [7:0]            PC_LEN,
  output logic [2:0]            PC_SIZE,
  output logic                  PC_READ_WRITE,
  input  logic                  PC_GRANTED,
  // deny statistics
  output logic                  DENY_PULSE,
  output logic [CNT_WIDTH-1:0]  DENY_COUNT
);

  typedef enum logic [2:0] {IDLE, CHECK, FWD, PASS, DENY} state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  arready_q;
  logic                  arvalid_q;
  logic                  dvalid_q;
  logic                  pulse_q;

  logic                  in_pass;
  logic                  in_deny;
  logic                  beat_last;
  logic [CNT_WIDTH-1:0]  cnt_d;

  assign in_pass   = (state_q == PASS);
  assign in_deny   = (state_q == DENY);
  assign beat_last = (beat_q == len_q);
  // The counter sticks at all-ones instead of wrapping.
  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
      dvalid_q  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            id_q      <= S_AXI_ARID;
            addr_q    <= S_AXI_ARADDR;
            len_q     <= S_AXI_ARLEN;
            size_q    <= S_AXI_ARSIZE;
            arready_q <= 1'b0;
            state_q   <= CHECK;
          end else begin
            arready_q <= 1'b1;
          end
        end
        CHECK: begin
          if (PC_GRANTED) begin
            arvalid_q <= 1'b1;
            state_q   <= FWD;
          end else begin
            beat_q   <= '0;
            dvalid_q <= 1'b1;
            pulse_q  <= 1'b1;
            cnt_q    <= cnt_d;
            state_q  <= DENY;
          end
        end
        FWD: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= PASS;
          end
        end
        PASS: begin
          if (M_AXI_RVALID && S_AXI_RREADY && M_AXI_RLAST) begin
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        DENY: begin
          if (S_AXI_RREADY) begin
            if (beat_last) begin
              dvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_q;

  assign PC_ID         = id_q;
  assign PC_ADDR       = addr_q;
  assign PC_LEN        = len_q;
  assign PC_SIZE       = size_q;
  assign PC_READ_WRITE = 1'b0;

  assign M_AXI_ARID    = id_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = size_q;
  assign M_AXI_ARVALID = arvalid_q;

  // In PASS the R channel is a wire-through; otherwise only DENY drives local beats.
  assign S_AXI_RVALID  = in_pass ? M_AXI_RVALID : dvalid_q;
  assign S_AXI_RID     = in_pass ? M_AXI_RID    : id_q;
  assign S_AXI_RDATA   = in_pass ? M_AXI_RDATA  : '0;
  assign S_AXI_RRESP   = in_pass ? M_AXI_RRESP  : (in_deny ? 2'b11 : 2'b00);
  assign S_AXI_RLAST   = in_pass ? M_AXI_RLAST  : (in_deny && beat_last);
  assign M_AXI_RREADY  = in_pass && S_AXI_RREADY;

  assign DENY_PULSE    = pulse_q;
  assign DENY_COUNT    = cnt_q;

endmodule
